// File: rtl/sha256_pkg.sv
// Shared definitions for the simplified SHA-256 core and its downstream stages.
// Holds the memory interface widths, the target-check FSM states and the result word layout.
package sha256_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 4;

  // Result word bit positions
  localparam int unsigned BELOW        = 0;
  localparam int unsigned EQUAL        = 1;
  localparam int unsigned DIFF_IDX_LSB = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdH,
    StRdT,
    StCmp,
    StWrite,
    StDone
  } state_e;

  function automatic logic [DATA_W-1:0] pack_result(input logic [IDX_W-1:0] diff_idx,
                                                    input logic             equal,
                                                    input logic             below);
    logic [DATA_W-1:0] word;
    word                              = '0;
    word[DIFF_IDX_LSB +: IDX_W]       = diff_idx;
    word[EQUAL]                       = equal;
    word[BELOW]                       = below;
    return word;
  endfunction

endpackage

// File: rtl/sha256_target_check.sv
// Compares a stored digest against a difficulty target as 256-bit big-endian numbers
// and writes a single result word back to the shared word-addressed memory.
module sha256_target_check
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] hash_addr,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic [ADDR_W-1:0] result_addr,
  output logic              done,
  output logic              busy,
  output logic              below_target,
  output logic              hash_equal,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] NumIdx  = IDX_W'(NUM_WORDS);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] hash_addr_q, target_addr_q, result_addr_q;
  logic [IDX_W-1:0]  idx_q, diff_idx_q;
  logic [DATA_W-1:0] h_word_q;
  logic              below_q, equal_q;

  logic h_lt_t, h_gt_t, last_word;

  assign mem_clk   = clk;
  // In CMP the target word is on the read bus, the digest word was captured in RD_T
  assign h_lt_t    = h_word_q < mem_read_data;
  assign h_gt_t    = h_word_q > mem_read_data;
  assign last_word = idx_q == LastIdx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRdH;
      StRdH:   state_d = StRdT;
      StRdT:   state_d = StCmp;
      StCmp: begin
        if (h_lt_t || h_gt_t || last_word) begin
          state_d = StWrite;
        end else begin
          state_d = StRdH;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy           = state_q != StIdle;
    done           = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = hash_addr_q;
    mem_write_data = '0;
    unique case (state_q)
      StRdH: mem_addr = hash_addr_q + ADDR_W'(idx_q);
      StRdT: mem_addr = target_addr_q + ADDR_W'(idx_q);
      StWrite: begin
        mem_we         = 1'b1;
        mem_addr       = result_addr_q;
        mem_write_data = pack_result(diff_idx_q, equal_q, below_q);
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hash_addr_q   <= '0;
      target_addr_q <= '0;
      result_addr_q <= '0;
      idx_q         <= '0;
      diff_idx_q    <= '0;
      h_word_q      <= '0;
      below_q       <= 1'b0;
      equal_q       <= 1'b0;
      below_target  <= 1'b0;
      hash_equal    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          hash_addr_q   <= hash_addr;
          target_addr_q <= target_addr;
          result_addr_q <= result_addr;
          idx_q         <= '0;
          // Previous verdict stays visible until a new run is accepted
          if (start) begin
            below_target <= 1'b0;
            hash_equal   <= 1'b0;
          end
        end
        StRdT: h_word_q <= mem_read_data;
        StCmp: begin
          if (h_lt_t) begin
            below_q    <= 1'b1;
            equal_q    <= 1'b0;
            diff_idx_q <= idx_q;
          end else if (h_gt_t) begin
            below_q    <= 1'b0;
            equal_q    <= 1'b0;
            diff_idx_q <= idx_q;
          end else if (last_word) begin
            below_q    <= 1'b0;
            equal_q    <= 1'b1;
            diff_idx_q <= NumIdx;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StWrite: begin
          below_target <= below_q;
          hash_equal   <= equal_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_target_check.sv
// Randomised self-checking bench for sha256_target_check: a memory image, a run-level
// reference model, and a per-cycle compare of every DUT output against it.
module tb_sha256_target_check;
  import sha256_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hash_addr = '0, target_addr = '0, result_addr = '0;
  logic        done, busy, below_target, hash_equal, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  sha256_target_check #(.NUM_WORDS(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .hash_addr     (hash_addr),
    .target_addr   (target_addr),
    .result_addr   (result_addr),
    .done          (done),
    .busy          (busy),
    .below_target  (below_target),
    .hash_equal    (hash_equal),
    .mem_clk       (mem_clk),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory environment: reads come from the preloaded image, writes are logged
  logic [31:0] img [0:65535];
  logic [31:0] rd_q = '0;
  int          wr_count = 0;
  logic [15:0] wr_addr_last = '0;
  logic [31:0] wr_data_last = '0;

  assign mem_read_data = rd_q;

  always @(posedge mem_clk) begin
    rd_q <= img[mem_addr];
    if (reset_n && mem_we) begin
      wr_count     <= wr_count + 1;
      wr_addr_last <= mem_addr;
      wr_data_last <= mem_write_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference: compare as 256-bit big-endian numbers, first differing word wins
  function automatic logic [31:0] ref_word(input logic [15:0] ha, input logic [15:0] ta);
    logic [15:0] a, b;
    for (int j = 0; j < N; j++) begin
      a = ha + 16'(j);
      b = ta + 16'(j);
      if (img[a] != img[b]) return (32'(j) << 8) | ((img[a] < img[b]) ? 32'd1 : 32'd0);
    end
    return (32'(N) << 8) | 32'd2;
  endfunction

  function automatic int lat_of(input logic [31:0] w);
    if (w[1]) return 3 * N + 2;
    return 3 * (int'(w[11:8]) + 1) + 2;
  endfunction

  // Run-level model: cyc=0 idle, cyc=c is the c-th cycle after the accepting edge
  int          cyc = 0;
  int          lat = 0;
  int          exp_writes = 0;
  logic [15:0] hq = '0, tq = '0, rq = '0;
  logic [31:0] exp_word = '0;
  logic        out_below = 1'b0, out_equal = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc       <= 0;
      hq        <= '0;
      tq        <= '0;
      rq        <= '0;
      out_below <= 1'b0;
      out_equal <= 1'b0;
    end else if (cyc == 0) begin
      hq <= hash_addr;
      tq <= target_addr;
      rq <= result_addr;
      if (start) begin
        cyc       <= 1;
        exp_word  <= ref_word(hash_addr, target_addr);
        lat       <= lat_of(ref_word(hash_addr, target_addr));
        out_below <= 1'b0;
        out_equal <= 1'b0;
      end
    end else if (cyc == lat) begin
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (cyc == lat - 1) begin
        out_below  <= exp_word[0];
        out_equal  <= exp_word[1];
        exp_writes <= exp_writes + 1;
      end
    end
  end

  function automatic logic [15:0] exp_addr();
    int j, ph;
    if (cyc == 0 || cyc == lat) return hq;
    if (cyc == lat - 1) return rq;
    j  = (cyc - 1) / 3;
    ph = (cyc - 1) % 3;
    if (ph == 0) return hq + 16'(j);
    if (ph == 1) return tq + 16'(j);
    return hq;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_we", mem_we, 1'b0);
      chk("rst_addr", {16'b0, mem_addr}, 32'h0);
      chk("rst_wdata", mem_write_data, 32'h0);
      chk1("rst_below", below_target, 1'b0);
      chk1("rst_equal", hash_equal, 1'b0);
    end else begin
      chk1("busy", busy, cyc != 0);
      chk1("done", done, cyc != 0 && cyc == lat);
      chk1("mem_we", mem_we, cyc != 0 && cyc == lat - 1);
      chk("mem_addr", {16'b0, mem_addr}, {16'b0, exp_addr()});
      chk("wdata", mem_write_data, (cyc != 0 && cyc == lat - 1) ? exp_word : 32'h0);
      chk1("below_target", below_target, out_below);
      chk1("hash_equal", hash_equal, out_equal);
      chk1("mem_clk", mem_clk, clk);
    end
  end

  // Start a run and count cycles from the sampling edge to the done pulse
  task automatic run(input logic [15:0] ha, input logic [15:0] ta, input logic [15:0] ra,
                     input bit hold, output int lat_meas);
    @(posedge clk);
    #2;
    hash_addr   = ha;
    target_addr = ta;
    result_addr = ra;
    start       = 1'b1;
    @(posedge clk);
    #2;
    if (!hold) start = 1'b0;
    lat_meas = 0;
    do begin
      @(negedge clk);
      lat_meas++;
    end while (!done && lat_meas < 200);
    chk1("done_timeout", done, 1'b1);
  endtask

  task automatic fill(input logic [15:0] ha, input logic [15:0] ta, input int k);
    logic [31:0] t, h;
    for (int j = 0; j < N; j++) begin
      t = $urandom;
      h = $urandom;
      if (j < k) h = t;
      else if (j == k && h == t) h = ~t;
      img[ta + 16'(j)] = t;
      img[ha + 16'(j)] = h;
    end
  endtask

  initial begin
    int lm, wc, k, n;
    logic [15:0] ha, ta, ra;
    for (int a = 0; a < 65536; a++) img[a] = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Word 0 decides: 0 < 1
    fill(16'h0100, 16'h0200, 0);
    img[16'h0100] = 32'h0;
    img[16'h0200] = 32'h1;
    run(16'h0100, 16'h0200, 16'h0300, 1'b0, lm);
    chk("t1_lat", 32'(lm), 32'd5);
    chk("t1_word", wr_data_last, 32'h00000001);
    chk("t1_waddr", {16'b0, wr_addr_last}, 32'h0300);
    chk1("t1_below", below_target, 1'b1);

    // Last word decides: 0xFFFFFFFF > 0
    fill(16'h0400, 16'h0500, 7);
    img[16'h0407] = 32'hFFFF_FFFF;
    img[16'h0507] = 32'h0;
    run(16'h0400, 16'h0500, 16'h0600, 1'b0, lm);
    chk("t2_lat", 32'(lm), 32'd26);
    chk("t2_word", wr_data_last, 32'h00000700);
    chk1("t2_below", below_target, 1'b0);

    // All equal
    fill(16'h0700, 16'h0800, 8);
    run(16'h0700, 16'h0800, 16'h0900, 1'b0, lm);
    chk("t3_lat", 32'(lm), 32'd26);
    chk("t3_word", wr_data_last, 32'h00000802);
    chk1("t3_equal", hash_equal, 1'b1);

    // Digest wraps past 0xFFFF
    fill(16'hFFFC, 16'h0100, 6);
    img[16'h0002] = 32'h10;
    img[16'h0106] = 32'h20;
    run(16'hFFFC, 16'h0100, 16'h1000, 1'b0, lm);
    chk("t4_lat", 32'(lm), 32'd23);
    chk("t4_word", wr_data_last, 32'h00000601);

    // Reset during RD_T of word 3: no write may land
    fill(16'h2000, 16'h2100, 8);
    wc = wr_count;
    @(posedge clk);
    #2;
    hash_addr   = 16'h2000;
    target_addr = 16'h2100;
    result_addr = 16'h2200;
    start       = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    n     = 0;
    while (cyc != 11 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("t5_reach", 32'(cyc), 32'd11);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    chk("t5_nowrite", 32'(wr_count), 32'(wc));
    run(16'h2000, 16'h2100, 16'h2200, 1'b0, lm);
    chk("t5_word", wr_data_last, 32'h00000802);
    chk("t5_lat", 32'(lm), 32'd26);

    // Start pulsed while busy is ignored
    fill(16'h3000, 16'h3100, 2);
    wc = wr_count;
    @(posedge clk);
    #2;
    hash_addr   = 16'h3000;
    target_addr = 16'h3100;
    result_addr = 16'h3200;
    start       = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("t6_one_write", 32'(wr_count - wc), 32'd1);

    // Randomised runs, some back-to-back with start held high
    for (int r = 0; r < 40; r++) begin
      k  = $urandom_range(0, N);
      ha = 16'($urandom);
      ta = ha + 16'h0040 + 16'($urandom_range(0, 16'h7000));
      ra = 16'($urandom);
      fill(ha, ta, k);
      run(ha, ta, ra, ($urandom_range(0, 3) == 0), lm);
      chk("rand_lat", 32'(lm), (k == N) ? 32'd26 : 32'(3 * (k + 1) + 2));
    end
    start = 1'b0;
    n     = 0;
    while (cyc != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("write_count", 32'(wr_count), 32'(exp_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
